// File: rtl/eyes_input_pkg.sv
// Shared constants for the Eyes player-input stage: PS/2 scan codes,
// joystick bit positions and the coin pulse state encoding.
package eyes_input_pkg;

    localparam logic [8:0] SC_UP    = 9'h075;
    localparam logic [8:0] SC_DOWN  = 9'h072;
    localparam logic [8:0] SC_LEFT  = 9'h06B;
    localparam logic [8:0] SC_RIGHT = 9'h074;
    localparam logic [8:0] SC_SPACE = 9'h029;
    localparam logic [8:0] SC_CTRL  = 9'h014;
    localparam logic [8:0] SC_F1    = 9'h005;
    localparam logic [8:0] SC_F2    = 9'h006;
    localparam logic [8:0] SC_5     = 9'h02E;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

endpackage

// File: rtl/eyes_input_if.sv
// Raw player inputs in, active-low pacman input bytes out.
interface eyes_input_if;

    logic [64:0] ps2_key;
    logic [15:0] joy;
    logic        orient_horz;
    logic        vblank;
    logic [7:0]  in0_reg;
    logic [7:0]  in1_reg;

    modport master (
        output ps2_key, joy, orient_horz, vblank,
        input  in0_reg, in1_reg
    );

    modport slave (
        input  ps2_key, joy, orient_horz, vblank,
        output in0_reg, in1_reg
    );

endinterface

// File: rtl/eyes_input_ctrl_coin.sv
// Frame-timed coin pulse generator with post-pulse lockout gap and a
// saturating queue of requests that arrive while a pulse or gap is running.
module coin_pulse_fsm
    import eyes_input_pkg::*;
#(
    parameter int COIN_FRAMES     = 4,
    parameter int COIN_GAP_FRAMES = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    input  logic tick,
    output logic coin
);

    localparam logic [3:0] PULSE_LAST = 4'(COIN_FRAMES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(COIN_GAP_FRAMES - 1);

    coin_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_pend, w_pend_nxt, w_pend_inc;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // A request landing on the gap's final tick is already visible in w_pend_inc.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_pend_inc  = (req && (r_pend != 2'd3)) ? r_pend + 2'd1 : r_pend;
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            PULSE: begin
                w_pend_nxt = w_pend_inc;
                if (tick) begin
                    if (r_cnt == PULSE_LAST) begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            GAP: begin
                w_pend_nxt = w_pend_inc;
                if (tick) begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt = 4'd0;
                        if (w_pend_inc != 2'd0) begin
                            w_state_nxt = PULSE;
                            w_pend_nxt  = w_pend_inc - 2'd1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign coin = (r_state == PULSE);

endmodule

// File: rtl/eyes_input_ctrl.sv
// Eyes player-input conditioning: PS/2 key tracking, joystick merge,
// orientation remap and registered active-low in0/in1 bytes.
module eyes_input_ctrl
    import eyes_input_pkg::*;
#(
    parameter int COIN_FRAMES     = 4,
    parameter int COIN_GAP_FRAMES = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    eyes_input_if.slave bus
);

    logic       r_ps2_tog;
    logic       r_key_up, r_key_down, r_key_left, r_key_right;
    logic       r_key_space, r_key_ctrl, r_key_f1, r_key_f2, r_key_coin;
    logic       r_coin_src, r_coin_src_d;
    logic       r_vb, r_vb_d;
    logic [7:0] r_in0, r_in1;

    logic       w_event, w_press, w_ext;
    logic [8:0] w_code9;
    logic       w_u, w_d, w_l, w_r;
    logic       w_up, w_down, w_left, w_right;
    logic       w_fire, w_start1, w_start2;
    logic       w_req, w_tick, w_coin;
    logic       w_unused;

    // PRNSCR/PAUSE carry extra prefix bytes above bit 24 and are dropped whole.
    assign w_event = (r_ps2_tog != bus.ps2_key[64]) && (bus.ps2_key[63:24] == 40'd0);
    assign w_press = (bus.ps2_key[15:8] != 8'hF0);
    assign w_ext   = (bus.ps2_key[15:8] == 8'hE0) || (bus.ps2_key[23:16] == 8'hE0);
    assign w_code9 = {w_ext, bus.ps2_key[7:0]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key_up    <= 1'b0;
            r_key_down  <= 1'b0;
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
            r_key_space <= 1'b0;
            r_key_ctrl  <= 1'b0;
            r_key_f1    <= 1'b0;
            r_key_f2    <= 1'b0;
            r_key_coin  <= 1'b0;
        end else if (w_event) begin
            if (w_code9[7:0] == SC_UP[7:0])    r_key_up    <= w_press;
            if (w_code9[7:0] == SC_DOWN[7:0])  r_key_down  <= w_press;
            if (w_code9[7:0] == SC_LEFT[7:0])  r_key_left  <= w_press;
            if (w_code9[7:0] == SC_RIGHT[7:0]) r_key_right <= w_press;
            if (w_code9 == SC_SPACE)           r_key_space <= w_press;
            if (w_code9 == SC_CTRL)            r_key_ctrl  <= w_press;
            if (w_code9 == SC_F1)              r_key_f1    <= w_press;
            if (w_code9 == SC_F2)              r_key_f2    <= w_press;
            if (w_code9 == SC_5)               r_key_coin  <= w_press;
        end
    end

    assign w_u      = r_key_up    | bus.joy[JOY_U];
    assign w_d      = r_key_down  | bus.joy[JOY_D];
    assign w_l      = r_key_left  | bus.joy[JOY_L];
    assign w_r      = r_key_right | bus.joy[JOY_R];
    assign w_fire   = r_key_space | r_key_ctrl | bus.joy[JOY_FIRE];
    assign w_start1 = r_key_f1 | bus.joy[JOY_START1];
    assign w_start2 = r_key_f2 | bus.joy[JOY_START2];

    assign w_up    = bus.orient_horz ? w_l : w_u;
    assign w_down  = bus.orient_horz ? w_r : w_d;
    assign w_left  = bus.orient_horz ? w_d : w_l;
    assign w_right = bus.orient_horz ? w_u : w_r;

    assign w_req  = r_coin_src & ~r_coin_src_d;
    assign w_tick = r_vb & ~r_vb_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ps2_tog    <= 1'b0;
            r_coin_src   <= 1'b0;
            r_coin_src_d <= 1'b0;
            r_vb         <= 1'b0;
            r_vb_d       <= 1'b0;
            r_in0        <= 8'hFF;
            r_in1        <= 8'hFF;
        end else begin
            r_ps2_tog    <= bus.ps2_key[64];
            r_coin_src   <= w_start1 | w_start2 | r_key_coin;
            r_coin_src_d <= r_coin_src;
            r_vb         <= bus.vblank;
            r_vb_d       <= r_vb;
            r_in0        <= ~{2'b00, w_coin, 1'b0, w_down, w_right, w_left, w_up};
            r_in1        <= ~{1'b0, w_start2, w_start1, w_fire, 4'b0000};
        end
    end

    coin_pulse_fsm #(
        .COIN_FRAMES     (COIN_FRAMES),
        .COIN_GAP_FRAMES (COIN_GAP_FRAMES)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .req     (w_req),
        .tick    (w_tick),
        .coin    (w_coin)
    );

    assign bus.in0_reg = r_in0;
    assign bus.in1_reg = r_in1;
    assign w_unused    = ^bus.joy[15:7];

endmodule

// File: tb/tb_eyes_input_ctrl.sv
// Directed bench for eyes_input_ctrl: vector table for key/joystick/remap
// decoding plus frame-level sequences for coin pulse timing and queueing.
module tb_eyes_input_ctrl;

    typedef struct {
        string       name;
        bit          keyEv;
        logic [39:0] hi;
        logic [23:0] lo;
        logic [15:0] joy;
        bit          orient;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    logic ps2Tog  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    vec_t vecs[$];

    eyes_input_if bus();

    eyes_input_ctrl #(
        .COIN_FRAMES     (4),
        .COIN_GAP_FRAMES (8)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void addVec(input string name, input bit keyEv, input logic [39:0] hi,
                                   input logic [23:0] lo, input logic [15:0] joy, input bit orient,
                                   input logic [7:0] exp0, input logic [7:0] exp1);
        vec_t v;
        v.name = name; v.keyEv = keyEv; v.hi = hi; v.lo = lo;
        v.joy = joy; v.orient = orient; v.exp0 = exp0; v.exp1 = exp1;
        vecs.push_back(v);
    endfunction

    task automatic sendKey(input logic [39:0] hi, input logic [23:0] lo);
        ps2Tog = ~ps2Tog;
        bus.ps2_key = {ps2Tog, hi, lo};
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.joy = v.joy;
        bus.orient_horz = v.orient;
        if (v.keyEv) sendKey(v.hi, v.lo);
        repeat (2) @(negedge clk_sys);
        checkOutput({v.name, " in0"}, bus.in0_reg, v.exp0);
        checkOutput({v.name, " in1"}, bus.in1_reg, v.exp1);
    endtask

    // One 20-cycle frame: coin is sampled just before vblank rises, then up
    // to three request pulses are issued in the low part of the frame.
    task automatic runFrame(input int reqs, input logic [15:0] mask, output bit lowAtRise);
        lowAtRise = ~bus.in0_reg[5];
        bus.vblank = 1'b1;
        repeat (4) @(negedge clk_sys);
        bus.vblank = 1'b0;
        repeat (2) @(negedge clk_sys);
        for (int i = 0; i < reqs; i++) begin
            bus.joy = bus.joy | mask;
            repeat (2) @(negedge clk_sys);
            bus.joy = bus.joy & ~mask;
            repeat (2) @(negedge clk_sys);
        end
        repeat (14 - 4 * reqs) @(negedge clk_sys);
    endtask

    // Pulses start 12 frames apart; each is seen low at 4 consecutive vblank rises.
    task automatic runCoinFrames(input string name, input int nFrames, input int nPulses,
                                 input int reqF1, input int reqF2, input logic [15:0] mask);
        bit low;
        bit expLow;
        int r;
        for (int f = 1; f <= nFrames; f++) begin
            r = (f == 1) ? reqF1 : ((f == 2) ? reqF2 : 0);
            runFrame(r, mask, low);
            expLow = (((f - 1) % 12) < 4) && (((f - 1) / 12) < nPulses);
            checks++;
            if (low !== expLow) begin
                errors++;
                $display("[TB] FAIL %s frame %0d: coin active %0b expected %0b", name, f, low, expLow);
            end
        end
    endtask

    task automatic issueReq(input logic [15:0] mask);
        bus.joy = bus.joy | mask;
        repeat (2) @(negedge clk_sys);
        bus.joy = bus.joy & ~mask;
        repeat (4) @(negedge clk_sys);
    endtask

    initial begin
        logic [7:0] seen0;
        logic [7:0] seen1;
        bit         dummy;

        bus.ps2_key = '0;
        bus.joy = 16'h0000;
        bus.orient_horz = 1'b0;
        bus.vblank = 1'b0;

        addVec("idle",            0, 40'h0, 24'h000000, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("joy R",           0, 40'h0, 24'h000000, 16'h0001, 0, 8'hFB, 8'hFF);
        addVec("joy L",           0, 40'h0, 24'h000000, 16'h0002, 0, 8'hFD, 8'hFF);
        addVec("joy D",           0, 40'h0, 24'h000000, 16'h0004, 0, 8'hF7, 8'hFF);
        addVec("joy U",           0, 40'h0, 24'h000000, 16'h0008, 0, 8'hFE, 8'hFF);
        addVec("horz L->up",      0, 40'h0, 24'h000000, 16'h0002, 1, 8'hFE, 8'hFF);
        addVec("horz U->right",   0, 40'h0, 24'h000000, 16'h0008, 1, 8'hFB, 8'hFF);
        addVec("horz R->down",    0, 40'h0, 24'h000000, 16'h0001, 1, 8'hF7, 8'hFF);
        addVec("horz D->left",    0, 40'h0, 24'h000000, 16'h0004, 1, 8'hFD, 8'hFF);
        addVec("joy combo",       0, 40'h0, 24'h000000, 16'h0019, 0, 8'hFA, 8'hEF);
        addVec("key 75 press",    1, 40'h0, 24'h000075, 16'h0000, 0, 8'hFE, 8'hFF);
        addVec("key 75 release",  1, 40'h0, 24'h00F075, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("key E06B press",  1, 40'h0, 24'h00E06B, 16'h0000, 0, 8'hFD, 8'hFF);
        addVec("key E06B rel",    1, 40'h0, 24'hE0F06B, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("key 74 press",    1, 40'h0, 24'h000074, 16'h0000, 0, 8'hFB, 8'hFF);
        addVec("key 74 release",  1, 40'h0, 24'h00F074, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("horz key 72",     1, 40'h0, 24'h000072, 16'h0000, 1, 8'hFD, 8'hFF);
        addVec("horz key 72 rel", 1, 40'h0, 24'h00F072, 16'h0000, 1, 8'hFF, 8'hFF);
        addVec("key 29 press",    1, 40'h0, 24'h000029, 16'h0000, 0, 8'hFF, 8'hEF);
        addVec("key 29 release",  1, 40'h0, 24'h00F029, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("key 14 press",    1, 40'h0, 24'h000014, 16'h0000, 0, 8'hFF, 8'hEF);
        addVec("key 14 release",  1, 40'h0, 24'h00F014, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("key E014 none",   1, 40'h0, 24'h00E014, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("prnscr ignored",  1, 40'h0000E012E0, 24'h000075, 16'h0000, 0, 8'hFF, 8'hFF);
        addVec("key 75 + joy U",  1, 40'h0, 24'h000075, 16'h0008, 0, 8'hFE, 8'hFF);
        addVec("key 75 + joy D",  0, 40'h0, 24'h000000, 16'h0004, 0, 8'hF6, 8'hFF);
        addVec("key 75 rel again",1, 40'h0, 24'h00F075, 16'h0000, 0, 8'hFF, 8'hFF);

        // Reset and idle behaviour.
        repeat (3) @(negedge clk_sys);
        checkOutput("in reset in0", bus.in0_reg, 8'hFF);
        checkOutput("in reset in1", bus.in1_reg, 8'hFF);
        reset_n = 1'b1;
        @(negedge clk_sys);
        checkOutput("after reset in0", bus.in0_reg, 8'hFF);
        checkOutput("after reset in1", bus.in1_reg, 8'hFF);
        seen0 = 8'hFF;
        seen1 = 8'hFF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (bus.in0_reg !== 8'hFF) seen0 = bus.in0_reg;
            if (bus.in1_reg !== 8'hFF) seen1 = bus.in1_reg;
        end
        checkOutput("idle 100 cycles in0", seen0, 8'hFF);
        checkOutput("idle 100 cycles in1", seen1, 8'hFF);
        for (int f = 0; f < 3; f++) begin
            runFrame(0, 16'h0000, dummy);
            checkOutput("idle vblank in0", bus.in0_reg, 8'hFF);
            checkOutput("idle vblank in1", bus.in1_reg, 8'hFF);
        end

        foreach (vecs[i]) applyStimulus(vecs[i]);
        bus.joy = 16'h0000;
        bus.orient_horz = 1'b0;
        repeat (4) @(negedge clk_sys);

        // Single pulse from a held start1.
        bus.joy = 16'h0020;
        repeat (4) @(negedge clk_sys);
        checkOutput("start1 held in1", bus.in1_reg, 8'hDF);
        checkOutput("start1 coin in0", bus.in0_reg, 8'hDF);
        runCoinFrames("single pulse", 16, 1, 0, 0, 16'h0020);
        checkOutput("start1 still held in1", bus.in1_reg, 8'hDF);
        bus.joy = 16'h0000;
        repeat (2) @(negedge clk_sys);
        checkOutput("start1 released in1", bus.in1_reg, 8'hFF);

        // Coincident start1/start2 edges are one request.
        bus.joy = 16'h0060;
        repeat (4) @(negedge clk_sys);
        checkOutput("both starts in1", bus.in1_reg, 8'h9F);
        runCoinFrames("dual start", 16, 1, 0, 0, 16'h0000);
        bus.joy = 16'h0000;
        repeat (4) @(negedge clk_sys);

        // Queueing: 1 starting request, then 4 more during the pulse.
        issueReq(16'h0020);
        checkOutput("queue first pulse in0", bus.in0_reg, 8'hDF);
        runCoinFrames("queue", 52, 4, 3, 1, 16'h0020);

        // Key-driven start1 and coin key inside one request window.
        sendKey(40'h0, 24'h000005);
        @(negedge clk_sys);
        sendKey(40'h0, 24'h00002E);
        repeat (4) @(negedge clk_sys);
        checkOutput("key F1 in1", bus.in1_reg, 8'hDF);
        checkOutput("key coin in0", bus.in0_reg, 8'hDF);
        sendKey(40'h0, 24'h00F005);
        @(negedge clk_sys);
        sendKey(40'h0, 24'h00F02E);
        @(negedge clk_sys);
        runCoinFrames("key coin", 16, 1, 0, 0, 16'h0000);

        // Asynchronous reset in the middle of a pulse.
        issueReq(16'h0040);
        checkOutput("pre-reset pulse in0", bus.in0_reg, 8'hDF);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1 checkOutput("async reset in0", bus.in0_reg, 8'hFF);
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        runCoinFrames("no resume", 16, 0, 0, 0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
